// File: rtl/uart_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame_ctrl
// Purpose  : Parses A5/addr/len/payload/checksum frames from a UART receiver
//            and replays committed payloads as sequential register writes.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_frame_ctrl #(
    parameter int CLK_FRE       = 50,
    parameter int BAUD_RATE     = 115200,
    parameter int MAX_LEN       = 16,
    parameter int TIMEOUT_BYTES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_data_valid,
    output logic       rx_data_ready,
    output logic       reg_wr_en,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code
);

    localparam int c_CYCLE = CLK_FRE * 1000000 / BAUD_RATE;
    localparam int c_LIMIT = TIMEOUT_BYTES * 10 * c_CYCLE;
    localparam int c_CNT_W = ($clog2(c_LIMIT + 1) > 24) ? $clog2(c_LIMIT + 1) : 24;
    localparam int c_IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [7:0]         c_HDR      = 8'hA5;
    localparam logic [8:0]         c_MAXLEN   = 9'(MAX_LEN);
    localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(c_LIMIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_LEN   = 3'd2,
        S_DATA  = 3'd3,
        S_CSUM  = 3'd4,
        S_WRITE = 3'd5
    } state_t;

    state_t             state_q;
    logic [7:0]         base_q;
    logic [7:0]         len_q;
    logic [7:0]         idx_q;
    logic [7:0]         csum_q;
    logic [c_CNT_W-1:0] tmo_q;
    logic               rdy_q;
    logic               wr_en_q;
    logic [7:0]         addr_q;
    logic [7:0]         wdata_q;
    logic               ok_q;
    logic               err_q;
    logic [1:0]         code_q;
    logic [7:0]         buf_q [MAX_LEN];

    logic               w_accept;
    logic               w_active;
    logic               w_tmo;
    logic [c_IDX_W-1:0] w_bidx;

    assign w_accept = rx_data_valid & rdy_q;
    assign w_active = (state_q == S_ADDR) || (state_q == S_LEN) ||
                      (state_q == S_DATA) || (state_q == S_CSUM);
    // An accepted byte on the limit edge wins over the timeout.
    assign w_tmo    = w_active && !w_accept && (tmo_q == c_TMO_LAST);
    assign w_bidx   = idx_q[c_IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (w_accept && (state_q == S_DATA)) begin
            buf_q[w_bidx] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            csum_q  <= '0;
            tmo_q   <= '0;
            rdy_q   <= 1'b0;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= '0;
        end else begin
            wr_en_q <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b1;

            if (w_active && !w_accept) begin
                tmo_q <= tmo_q + c_CNT_W'(1);
            end else begin
                tmo_q <= '0;
            end

            if (w_tmo) begin
                err_q   <= 1'b1;
                code_q  <= 2'd3;
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (w_accept && (rx_data == c_HDR)) begin
                            csum_q  <= '0;
                            state_q <= S_ADDR;
                        end
                    end
                    S_ADDR: begin
                        if (w_accept) begin
                            base_q  <= rx_data;
                            csum_q  <= csum_q + rx_data;
                            state_q <= S_LEN;
                        end
                    end
                    S_LEN: begin
                        if (w_accept) begin
                            if ((rx_data == 8'd0) || ({1'b0, rx_data} > c_MAXLEN)) begin
                                err_q   <= 1'b1;
                                code_q  <= 2'd2;
                                state_q <= S_IDLE;
                            end else begin
                                len_q   <= rx_data;
                                csum_q  <= csum_q + rx_data;
                                idx_q   <= '0;
                                state_q <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        if (w_accept) begin
                            csum_q <= csum_q + rx_data;
                            idx_q  <= idx_q + 8'd1;
                            if (idx_q == len_q - 8'd1) begin
                                state_q <= S_CSUM;
                            end
                        end
                    end
                    S_CSUM: begin
                        if (w_accept) begin
                            if (rx_data == csum_q) begin
                                idx_q   <= '0;
                                rdy_q   <= 1'b0;
                                state_q <= S_WRITE;
                            end else begin
                                err_q   <= 1'b1;
                                code_q  <= 2'd1;
                                state_q <= S_IDLE;
                            end
                        end
                    end
                    S_WRITE: begin
                        // idx == len means every byte has been written out.
                        if (idx_q == len_q) begin
                            ok_q    <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            rdy_q   <= 1'b0;
                            wr_en_q <= 1'b1;
                            addr_q  <= base_q + idx_q;
                            wdata_q <= buf_q[w_bidx];
                            idx_q   <= idx_q + 8'd1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign rx_data_ready = rdy_q;
    assign reg_wr_en     = wr_en_q;
    assign reg_addr      = addr_q;
    assign reg_wdata     = wdata_q;
    assign frame_ok      = ok_q;
    assign frame_err     = err_q;
    assign err_code      = code_q;

endmodule
`default_nettype wire

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
Frame controller behind the UART receiver. It consumes received bytes through the valid/ready handshake and parses fixed-format command frames: header 0xA5, address, length, payload, checksum. Frames that pass the checksum are replayed as sequential single-cycle register writes. Malformed or stalled frames are discarded and an error is flagged.

Parameters:
CLK_FRE, 50, clock frequency in MHz
BAUD_RATE, 115200, serial baud rate; must match the receiver
MAX_LEN, 16, maximum payload bytes per frame (1..255)
TIMEOUT_BYTES, 16, inter-byte gap, in 10-bit character times, that aborts a frame

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous reset, active low
rx_data  input  8  byte from receiver
rx_data_valid  input  1  rx_data valid
rx_data_ready  output  1  controller accepts byte this cycle
reg_wr_en  output  1  register write strobe, one cycle per byte
reg_addr  output  8  write address
reg_wdata  output  8  write data
frame_ok  output  1  one-cycle pulse, frame committed
frame_err  output  1  one-cycle pulse, frame discarded
err_code  output  2  cause of last error: 1 checksum, 2 bad length, 3 timeout; held until next error

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active low.
- Reset values: all outputs 0; state S_IDLE; payload buffer contents are don't-care.
- A byte is accepted only when rx_data_valid and rx_data_ready are both high on the same clk edge.
- rx_data_ready is 1 in S_IDLE, S_ADDR, S_LEN, S_DATA and S_CSUM. It is 0 in S_WRITE.
- Checksum: sum of addr, len and all payload bytes, modulo 256, in an 8-bit accumulator.
- S_IDLE: an accepted 0xA5 moves to S_ADDR and clears the accumulator. Any other accepted byte is dropped silently.
- S_ADDR: the accepted byte is latched as base address and added to the accumulator -> S_LEN.
- S_LEN: len of 0 or len > MAX_LEN -> frame_err pulse, err_code=2, S_IDLE. Otherwise latch len, add it to the accumulator, clear the index -> S_DATA.
- S_DATA: each accepted byte goes to buffer[index] and is added to the accumulator; index increments. After the len-th byte -> S_CSUM.
- S_CSUM: accepted byte equal to the accumulator -> S_WRITE with index cleared. Mismatch -> frame_err, err_code=1, S_IDLE, no writes.
- S_WRITE: one write per cycle for i=0..len-1, with reg_wr_en=1, reg_addr=(base+i) mod 256 (wraps 0xFF->0x00), reg_wdata=buffer[i]. The cycle after the last write, frame_ok pulses and the state returns to S_IDLE. Latency from the checksum accept edge to the first reg_wr_en is 1 cycle.
- Timeout: CYCLE = CLK_FRE*1000000/BAUD_RATE. Limit = TIMEOUT_BYTES*10*CYCLE clk cycles; the counter is at least 24 bits wide.
  - The counter clears on every accepted byte and on entry to S_ADDR.
  - It counts only in S_ADDR, S_LEN, S_DATA and S_CSUM.
  - Reaching the limit -> frame_err, err_code=3, S_IDLE. A byte accepted on the same edge wins and clears the counter.
- A header byte received mid-frame is treated as ordinary data; there is no resynchronisation except via error, timeout or reset.
- frame_ok and frame_err are never high in the same cycle.
- Reset mid-frame or mid-write: immediate return to S_IDLE with outputs 0. Remaining writes are not issued.

Test Plan:
- Send A5 10 02 11 22 45 -> writes (0x10,0x11) then (0x11,0x22) on consecutive cycles; frame_ok pulses once; frame_err stays 0.
- Send A5 10 02 11 22 46 -> no reg_wr_en; frame_err pulses; err_code=1.
- Send A5 10 00, then separately A5 10 11 (len 17 > MAX_LEN) -> frame_err each time with err_code=2; the next valid frame is accepted normally.
- Send A5 FF 02 01 02 04 -> writes (0xFF,0x01) then (0x00,0x02); frame_ok pulses.
- Send A5 10, then idle for more than 16*10*434 cycles -> frame_err with err_code=3. A following valid frame commits.
- Assert rst_n low during the S_DATA bytes of a frame -> all outputs 0. Garbage bytes 33 44 before a header are ignored, and the subsequent valid frame commits correctly.
